// File: rtl/boot_pkg.sv
// Shared boot sequencer types and default geometry.
package boot_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_IMEM_DEPTH = 256;
    localparam int DEF_NUM_REGS   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR_RF,
        ST_LOAD,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } boot_state_e;

endpackage

// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: clears the register file, streams a program image into imem, then releases the core.
// Optional image checksum stage is compiled in when BOOT_CKSUM_EN is defined.
module boot_seq_ctrl
    import boot_pkg::*;
#(
    parameter  int XLEN       = DEF_XLEN,
    parameter  int IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter  int NUM_REGS   = DEF_NUM_REGS,
    localparam int IMEM_AW    = $clog2(IMEM_DEPTH),
    localparam int RF_AW      = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ld_valid,
    input  logic [XLEN-1:0]    ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [XLEN-1:0]    imem_wdata,
    output logic               rf_we,
    output logic [RF_AW-1:0]   rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               core_reset_n,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [IMEM_AW:0]   word_count
);

    localparam int WC_W = IMEM_AW + 1;

    boot_state_e        state_q, state_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_waddr_q, imem_waddr_d;
    logic [XLEN-1:0]    imem_wdata_q, imem_wdata_d;
    logic               rf_we_q, rf_we_d;
    logic [RF_AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic               core_reset_n_q, core_reset_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [WC_W-1:0]    wc_q, wc_d;
`ifdef BOOT_CKSUM_EN
    logic [XLEN-1:0]    sum_q, sum_d;
`endif
    logic               hs;

    assign ld_ready = (state_q == ST_LOAD) || (state_q == ST_CHK);
    assign hs       = ld_valid && ld_ready;

    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        wc_d         = wc_q;
`ifdef BOOT_CKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_d    = ST_CLR_RF;
                    rf_we_d    = 1'b1;
                    rf_waddr_d = '0;
                    wc_d       = '0;
`ifdef BOOT_CKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            ST_CLR_RF: begin
                if (rf_waddr_q == RF_AW'(NUM_REGS - 1)) begin
                    state_d = ST_LOAD;
                end else begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = rf_waddr_q + RF_AW'(1);
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    // A beat beyond the last imem word is a fatal image, not a wrap.
                    if (wc_q == WC_W'(IMEM_DEPTH)) begin
                        state_d = ST_ERR;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_waddr_d = wc_q[IMEM_AW-1:0];
                        imem_wdata_d = ld_data;
                        wc_d         = wc_q + WC_W'(1);
`ifdef BOOT_CKSUM_EN
                        sum_d        = sum_q + ld_data;
                        if (ld_last) state_d = ST_CHK;
`else
                        if (ld_last) state_d = ST_RUN;
`endif
                    end
                end
            end
`ifdef BOOT_CKSUM_EN
            ST_CHK: begin
                if (hs) state_d = (ld_data == sum_q) ? ST_RUN : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered images of the next state.
        busy_d         = (state_d == ST_CLR_RF) || (state_d == ST_LOAD) || (state_d == ST_CHK);
        done_d         = (state_d == ST_RUN);
        core_reset_n_d = (state_d == ST_RUN);
        err_d          = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            imem_we_q      <= 1'b0;
            imem_waddr_q   <= '0;
            imem_wdata_q   <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            core_reset_n_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            wc_q           <= '0;
`ifdef BOOT_CKSUM_EN
            sum_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            imem_we_q      <= imem_we_d;
            imem_waddr_q   <= imem_waddr_d;
            imem_wdata_q   <= imem_wdata_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            core_reset_n_q <= core_reset_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            wc_q           <= wc_d;
`ifdef BOOT_CKSUM_EN
            sum_q          <= sum_d;
`endif
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_waddr   = imem_waddr_q;
    assign imem_wdata   = imem_wdata_q;
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = '0;
    assign core_reset_n = core_reset_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign word_count   = wc_q;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed-plus-random bench for boot_seq_ctrl; checksum steps run only when BOOT_CKSUM_EN is defined.
module tb_boot_seq_ctrl;

    localparam int XLEN  = 32;
    localparam int DEPTH = 256;
    localparam int NREG  = 4;
    localparam int AW    = 8;

    logic            clk = 1'b0;
    logic            reset, start, ld_valid, ld_last;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready, imem_we, rf_we, core_reset_n, busy, done, err;
    logic [AW-1:0]   imem_waddr;
    logic [XLEN-1:0] imem_wdata, rf_wdata;
    logic [1:0]      rf_waddr;
    logic [AW:0]     word_count;

    int n_checks = 0;
    int n_err    = 0;

    logic [XLEN-1:0] img [0:299];
    int              nwr = 0;
    logic [AW-1:0]   log_addr [0:2047];
    logic [XLEN-1:0] log_data [0:2047];

    boot_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .core_reset_n(core_reset_n), .busy(busy), .done(done), .err(err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Reference imem: every write the sequencer issues, in order.
    always @(negedge clk) begin
        if (imem_we && nwr < 2048) begin
            log_addr[nwr] <= imem_waddr;
            log_data[nwr] <= imem_wdata;
            nwr           <= nwr + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_imem_we"}, imem_we, 0);
        chk({tag, "_imem_waddr"}, imem_waddr, 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_rf_waddr"}, rf_waddr, 0);
        chk({tag, "_rf_wdata"}, rf_wdata, 0);
        chk({tag, "_core_reset_n"}, core_reset_n, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_word_count"}, word_count, 0);
    endtask

    // Pulse start, then expect one zeroing write per register, core held in reset.
    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            chk("clr_rf_we", rf_we, 1);
            chk("clr_rf_waddr", rf_waddr, r);
            chk("clr_rf_wdata", rf_wdata, 0);
            chk("clr_core_reset_n", core_reset_n, 0);
            chk("clr_busy", busy, 1);
            chk("clr_done", done, 0);
            chk("clr_err", err, 0);
            tick();
        end
        chk("load_rf_we", rf_we, 0);
        chk("load_ld_ready", ld_ready, 1);
        chk("load_word_count", word_count, 0);
    endtask

    // Offer img[0..n-1]; toggle alternates ld_valid. Returns cycles spent.
    task automatic send_words(input int n, input bit set_last, input bit toggle, output int cyc);
        int  i  = 0;
        bit  ph = 1'b1;
        cyc = 0;
        while (i < n && cyc < 2000) begin
            ld_valid = toggle ? ph : 1'b1;
            ph       = ~ph;
            ld_data  = img[i];
            ld_last  = set_last && (i == n - 1);
            if (ld_valid && ld_ready) i++;
            tick();
            cyc++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (i < n) chk("send_timeout", i, n);
    endtask

    // Compare writes since base against the expected image: addresses 0..n-1 in order.
    task automatic check_image(input int base, input int n);
        int bad = 0;
        @(negedge clk);
        #1;
        chk("imem_write_count", nwr - base, n);
        for (int k = 0; k < n; k++) begin
            if (log_addr[base + k] !== k[AW-1:0] || log_data[base + k] !== img[k]) bad++;
        end
        chk("imem_content_bad", bad, 0);
    endtask

`ifdef BOOT_CKSUM_EN
    task automatic send_cksum(input int n, input logic [XLEN-1:0] delta);
        logic [XLEN-1:0] s = '0;
        for (int k = 0; k < n; k++) s = s + img[k];
        chk("chk_ld_ready", ld_ready, 1);
        chk("chk_busy", busy, 1);
        chk("chk_done", done, 0);
        ld_valid = 1'b1;
        ld_data  = s + delta;
        tick();
        ld_valid = 1'b0;
    endtask
`endif

    initial begin
        int cyc;
        int base;
        reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();
        chk("idle_core_reset_n", core_reset_n, 0);
        chk("idle_ld_ready", ld_ready, 0);

        // 8-word image, ld_valid held high
        for (int k = 0; k < 8; k++) img[k] = $urandom;
        do_start();
        base = nwr;
        send_words(8, 1'b1, 1'b0, cyc);
        chk("throughput_cycles", cyc, 8);
        chk("img8_word_count", word_count, 8);
`ifdef BOOT_CKSUM_EN
        send_cksum(8, '0);
`endif
        chk("img8_done", done, 1);
        chk("img8_core_reset_n", core_reset_n, 1);
        chk("img8_busy", busy, 0);
        chk("img8_err", err, 0);
        chk("img8_ld_ready", ld_ready, 0);
        check_image(base, 8);

        // Reboot from RUN with a gappy valid stream
        for (int k = 0; k < 5; k++) img[k] = $urandom;
        do_start();
        base = nwr;
        send_words(5, 1'b1, 1'b1, cyc);
        chk("toggle_word_count", word_count, 5);
`ifdef BOOT_CKSUM_EN
        send_cksum(5, '0);
`endif
        chk("toggle_done", done, 1);
        chk("toggle_core_reset_n", core_reset_n, 1);
        check_image(base, 5);

`ifdef BOOT_CKSUM_EN
        img[0] = 1; img[1] = 2; img[2] = 3;
        do_start();
        send_words(3, 1'b1, 1'b0, cyc);
        send_cksum(3, '0);
        chk("cksum_ok_done", done, 1);
        chk("cksum_ok_err", err, 0);
        do_start();
        send_words(3, 1'b1, 1'b0, cyc);
        send_cksum(3, 1);
        chk("cksum_bad_err", err, 1);
        chk("cksum_bad_done", done, 0);
        chk("cksum_bad_core_reset_n", core_reset_n, 0);
        chk("cksum_bad_ld_ready", ld_ready, 0);
`endif

        // Overflow: DEPTH+1 words with no last flag
        for (int k = 0; k < DEPTH + 1; k++) img[k] = $urandom;
        do_start();
        base = nwr;
        send_words(DEPTH + 1, 1'b0, 1'b0, cyc);
        chk("ovf_err", err, 1);
        chk("ovf_ld_ready", ld_ready, 0);
        chk("ovf_core_reset_n", core_reset_n, 0);
        chk("ovf_done", done, 0);
        chk("ovf_busy", busy, 0);
        chk("ovf_word_count", word_count, DEPTH);
        check_image(base, DEPTH);
        chk("ovf_addr255_data", log_data[base + DEPTH - 1], img[DEPTH - 1]);
        chk("ovf_core_reset_n_held", core_reset_n, 0);

        // Reset mid-load, then a one-word image from address 0
        for (int k = 0; k < 3; k++) img[k] = $urandom;
        do_start();
        send_words(3, 1'b0, 1'b0, cyc);
        chk("midload_word_count", word_count, 3);
        reset = 1'b1;
        tick();
        check_reset_vals("midrst");
        reset = 1'b0;
        tick();
        img[0] = $urandom;
        do_start();
        base = nwr;
        send_words(1, 1'b1, 1'b0, cyc);
        chk("one_word_count", word_count, 1);
`ifdef BOOT_CKSUM_EN
        send_cksum(1, '0);
`endif
        chk("one_done", done, 1);
        chk("one_core_reset_n", core_reset_n, 1);
        check_image(base, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
